// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state type, the digit width and the per-digit add-3 rule.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam int BCD_DIGIT_W = 4;

  // Double-dabble correction: a digit of 5..9 would carry wrongly after the shift.
  function automatic logic [3:0] digit_adj(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int k = 0; k < n; k++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One-digit add-3 correction cell; the converter instantiates one per BCD digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = digit_adj(digit);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
// The result register only updates on completion, so downstream never sees partial values.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W_BIN    = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            i_start,
  input  logic [W_BIN-1:0]                i_bin,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [BCD_DIGIT_W*N_DIGITS-1:0] o_bcd
);

  localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
  localparam int CNT_W = (W_BIN > 1) ? $clog2(W_BIN) : 1;

  if (W_BIN < 1 || W_BIN > 26 || N_DIGITS < 1 || N_DIGITS > 8 ||
      pow10(N_DIGITS) <= ((64'd1 << W_BIN) - 64'd1)) begin : g_bad_params
    $error("bin_to_bcd_seq: W_BIN=%0d needs more than N_DIGITS=%0d digits", W_BIN, N_DIGITS);
  end

  bcd_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [W_BIN-1:0] bin_sr_reg, bin_sr_next;
  logic [BCD_W-1:0] bcd_sr_reg, bcd_sr_next;
  logic [BCD_W-1:0] bcd_out_reg, bcd_out_next;
  logic             busy_reg;
  logic             done_reg, done_next;
  logic [BCD_W-1:0] bcd_adj;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .digit   (bcd_sr_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .adjusted(bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bin_sr_next  = bin_sr_reg;
    bcd_sr_next  = bcd_sr_reg;
    bcd_out_next = bcd_out_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          bin_sr_next = i_bin;
          bcd_sr_next = '0;
          cnt_next    = CNT_W'(W_BIN - 1);
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        // Corrected digits and the binary operand shift as one register; the binary MSB enters BCD bit 0.
        {bcd_sr_next, bin_sr_next} = {bcd_adj, bin_sr_reg} << 1;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bcd_out_next = bcd_sr_reg;
        done_next    = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bin_sr_reg  <= '0;
      bcd_sr_reg  <= '0;
      bcd_out_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bin_sr_reg  <= bin_sr_next;
      bcd_sr_reg  <= bcd_sr_next;
      bcd_out_reg <= bcd_out_next;
      busy_reg    <= (state_next != IDLE);
      done_reg    <= done_next;
    end
  end

  assign o_busy = busy_reg;
  assign o_done = done_reg;
  assign o_bcd  = bcd_out_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed corner cases plus random operands
// checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clock;
  logic        reset;
  logic        i_start;
  logic [15:0] i_bin;
  logic        o_busy;
  logic        o_done;
  logic [19:0] o_bcd;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.W_BIN(16), .N_DIGITS(5)) dut (
    .clock  (clock),
    .reset  (reset),
    .i_start(i_start),
    .i_bin  (i_bin),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_bcd  (o_bcd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Output stability and single-cycle done pulse, watched continuously.
  logic [19:0] prev_bcd;
  logic        prev_valid = 1'b0;
  logic        prev_done  = 1'b0;
  always @(negedge clock) begin
    if (reset && prev_valid && !o_done) check("bcd_hold", o_bcd, prev_bcd);
    if (o_done) check("done_one_cycle", prev_done, 1'b0);
    prev_bcd   = o_bcd;
    prev_valid = reset;
    prev_done  = o_done;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_conv(input logic [15:0] v);
    i_bin   = v;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1'b1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!o_done && lat < 40) begin
      tick();
      lat++;
    end
    if (!o_done) check("done_timeout", o_done, 1'b1);
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input bit scramble);
    int lat;
    start_conv(v);
    if (scramble) i_bin = 16'($urandom);
    wait_done(lat);
    check({tag, "_bcd"}, o_bcd, ref_bcd(v));
    check({tag, "_lat"}, lat, 17);
    check({tag, "_busy_at_done"}, o_busy, 1'b0);
    $display("conv %s bin=%0d bcd=%05h lat=%0d", tag, v, o_bcd, lat);
  endtask

  initial begin
    int lat;
    int last;
    int pulses;
    reset   = 1'b0;
    i_start = 1'b0;
    i_bin   = '0;
    tick();
    tick();
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_bcd", o_bcd, 20'h0);
    reset = 1'b1;
    tick();

    // Directed values including extremes.
    convert("zero", 16'd0, 1'b0);
    convert("max", 16'd65535, 1'b0);
    convert("v1234", 16'd1234, 1'b0);
    convert("v9", 16'd9, 1'b0);

    // Starts during SHIFT and during DONE are ignored.
    start_conv(16'd4321);
    for (int c = 1; c <= 17; c++) begin
      if (c == 3)  begin i_start = 1'b1; i_bin = 16'd1111; end
      if (c == 17) begin i_start = 1'b1; i_bin = 16'd2222; end
      tick();
      i_start = 1'b0;
      if (c < 17) check("ign_no_early_done", o_done, 1'b0);
    end
    check("ign_done", o_done, 1'b1);
    check("ign_bcd", o_bcd, ref_bcd(4321));
    tick();
    check("ign_not_restarted", o_busy, 1'b0);
    $display("conv ignore bin=4321 bcd=%05h", o_bcd);

    // Asynchronous reset mid-conversion.
    start_conv(16'd1234);
    repeat (8) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_bcd", o_bcd, 20'h0);
    check("mid_rst_done", o_done, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    pulses = 0;
    repeat (25) begin
      tick();
      if (o_done) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    $display("conv reset_mid bcd=%05h busy=%0b", o_bcd, o_busy);
    convert("after_rst", 16'd777, 1'b0);

    // Start held high: back-to-back conversions every 18 cycles.
    i_bin   = 16'd42;
    i_start = 1'b1;
    last    = -1;
    pulses  = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (o_done) begin
        check("b2b_bcd", o_bcd, ref_bcd(42));
        if (last >= 0) check("b2b_period", n - last, 18);
        $display("conv b2b bin=42 bcd=%05h cycle=%0d", o_bcd, n);
        last = n;
        pulses++;
      end
    end
    check("b2b_pulse_count", pulses, 4);
    i_start = 1'b0;
    lat = 0;
    while (o_busy && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b_drain", o_busy, 1'b0);
    tick();

    // Random operands; i_bin is scrambled after acceptance.
    for (int i = 0; i < 1000; i++) begin
      convert("rand", 16'($urandom_range(0, 65535)), 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
